log_uart_streamer: RTL and testbench



---
 rtl/log_uart_streamer.sv | 93 +++++++++
 tb/tb_log_uart_streamer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/log_uart_streamer.sv
// log_uart_streamer: dumps the whole log RAM in address order as UART frames on o_tx.
// Define LOG_STREAMER_PARITY_EN to send an even-parity bit between the data and stop bits.
module log_uart_streamer #(
    parameter int NB_ADDR      = 10,
    parameter int NB_DATA      = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_ram_full,
    output logic               o_ram_rd_en,
    output logic [NB_ADDR-1:0] o_ram_rd_addr,
    input  logic [NB_DATA-1:0] i_ram_rd_data,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_done
);
`ifdef LOG_STREAMER_PARITY_EN
    localparam int NB_FRAME = NB_DATA + 3;
`else
    localparam int NB_FRAME = NB_DATA + 2;
`endif
    localparam int NB_IDX  = $clog2(NB_FRAME);
    localparam int NB_BAUD = $clog2(CLKS_PER_BIT);
    typedef enum logic [2:0] {IDLE, READ, WAIT, LOAD, SHIFT, DONE} state_t;
    state_t state, state_next;
    logic start_prev, start_edge, bit_end, frame_end, last_addr, tx;
    logic [NB_BAUD-1:0] baud;
    logic [NB_IDX-1:0] bit_idx;
    logic [NB_ADDR-1:0] addr;
    // Start bit is driven directly at LOAD; the shift register holds the remaining frame bits.
    logic [NB_FRAME-2:0] shreg, frame;
`ifdef LOG_STREAMER_PARITY_EN
    assign frame = {1'b1, ^i_ram_rd_data, i_ram_rd_data};
`else
    assign frame = {1'b1, i_ram_rd_data};
`endif
    always_comb begin
        start_edge    = i_start & ~start_prev;
        bit_end       = baud == '0;
        frame_end     = bit_end && bit_idx == NB_IDX'(NB_FRAME - 1);
        last_addr     = addr == '1;
        o_ram_rd_en   = state == READ;
        o_busy        = state != IDLE;
        o_done        = state == DONE;
        o_ram_rd_addr = addr;
        o_tx          = tx;
        state_next    = state;
        case (state)
            IDLE:    state_next = (start_edge && i_ram_full) ? READ : IDLE;
            READ:    state_next = WAIT;
            WAIT:    state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   state_next = frame_end ? (last_addr ? DONE : READ) : SHIFT;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (i_reset) begin
            state      <= IDLE;
            start_prev <= 1'b0;
            baud       <= '0;
            bit_idx    <= '0;
            shreg      <= '1;
            addr       <= '0;
            tx         <= 1'b1;
        end else begin
            state      <= state_next;
            start_prev <= i_start;
            if (state == IDLE && start_edge && i_ram_full)
                addr <= '0;
            if (state == LOAD) begin
                shreg   <= frame;
                tx      <= 1'b0;
                baud    <= NB_BAUD'(CLKS_PER_BIT - 1);
                bit_idx <= '0;
            end
            if (state == SHIFT) begin
                if (!bit_end)
                    baud <= baud - 1'b1;
                else if (!frame_end) begin
                    shreg   <= {1'b1, shreg[NB_FRAME-2:1]};
                    tx      <= shreg[0];
                    baud    <= NB_BAUD'(CLKS_PER_BIT - 1);
                    bit_idx <= bit_idx + 1'b1;
                end else if (!last_addr)
                    addr <= addr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_log_uart_streamer.sv
// tb_log_uart_streamer: scoreboard bench; a UART receiver decodes o_tx and compares against queued expectations.
module tb_log_uart_streamer;
    localparam int NB_ADDR = 2;
    localparam int NB_DATA = 8;
    localparam int CPB     = 4;
    localparam int DEPTH   = 1 << NB_ADDR;
`ifdef LOG_STREAMER_PARITY_EN
    localparam int NF = NB_DATA + 3;
`else
    localparam int NF = NB_DATA + 2;
`endif
    localparam int P = NF * CPB + 3;

    typedef struct {int cyc; int val;} exp_t;
    exp_t fq[$], aq[$], dq[$];

    logic clock = 1'b0, i_reset = 1'b1, i_start = 1'b0, i_ram_full = 1'b0;
    logic o_ram_rd_en, o_tx, o_busy, o_done;
    logic [NB_ADDR-1:0] o_ram_rd_addr;
    logic [NB_DATA-1:0] i_ram_rd_data = '0;
    logic [NB_DATA-1:0] mem [DEPTH];
    int cyc = 0, checks = 0, errors = 0;

    log_uart_streamer #(.NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA), .CLKS_PER_BIT(CPB)) dut (
        .clock(clock), .i_reset(i_reset), .i_start(i_start), .i_ram_full(i_ram_full),
        .o_ram_rd_en(o_ram_rd_en), .o_ram_rd_addr(o_ram_rd_addr), .i_ram_rd_data(i_ram_rd_data),
        .o_tx(o_tx), .o_busy(o_busy), .o_done(o_done));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock) if (o_ram_rd_en) i_ram_rd_data <= mem[o_ram_rd_addr];

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    int rx_cnt = -1, rx_start = 0;
    logic [NF-1:0] rx_bits;
    logic rx_cur, rx_glitch;
    always @(negedge clock) begin
        exp_t e;
        int d;
        if (i_reset) rx_cnt = -1;
        else begin
            if (rx_cnt < 0 && o_tx === 1'b0) begin
                rx_cnt = 0; rx_start = cyc; rx_glitch = 1'b0;
            end
            if (rx_cnt >= 0) begin
                if (rx_cnt % CPB == 0) begin
                    rx_bits = {o_tx, rx_bits[NF-1:1]};
                    rx_cur  = o_tx;
                end else if (o_tx !== rx_cur) rx_glitch = 1'b1;
                rx_cnt++;
                if (rx_cnt == NF * CPB) begin
                    rx_cnt = -1;
                    e = fq.size() != 0 ? fq.pop_front() : '{-1, -1};
                    d = int'(rx_bits[NB_DATA:1]);
                    chk("frame_data", d, e.val);
                    chk("frame_start_cycle", rx_start, e.cyc);
                    chk("stop_bit", int'(rx_bits[NF-1]), 1);
                    chk("bit_hold", int'(rx_glitch), 0);
`ifdef LOG_STREAMER_PARITY_EN
                    chk("parity_bit", int'(rx_bits[NF-2]), int'(^rx_bits[NB_DATA:1]));
`endif
                end
            end
        end
        if (o_ram_rd_en === 1'b1) begin
            e = aq.size() != 0 ? aq.pop_front() : '{-1, -1};
            chk("rd_addr", int'(o_ram_rd_addr), e.val);
            chk("rd_cycle", cyc, e.cyc);
        end
        if (o_done === 1'b1) begin
            e = dq.size() != 0 ? dq.pop_front() : '{-1, -1};
            chk("done_cycle", cyc, e.cyc);
            chk("done_busy", int'(o_busy), 1);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(output int n);
        i_start = 1'b1;
        n = cyc;
        step();
        i_start = 1'b0;
    endtask

    // Reference: word k is read at n+1+k*P, its start bit at n+4+k*P, done after the last frame.
    task automatic expect_dump(input int n);
        for (int k = 0; k < DEPTH; k++) begin
            aq.push_back('{n + 1 + k * P, k});
            fq.push_back('{n + 4 + k * P, int'(mem[k])});
        end
        dq.push_back('{n + 1 + DEPTH * P, 0});
    endtask

    task automatic drain(input string name);
        int i = 0;
        while ((fq.size() + aq.size() + dq.size()) != 0 && i < DEPTH * P + 50) begin
            step();
            i++;
        end
        chk({name, "_pending"}, fq.size() + aq.size() + dq.size(), 0);
        fq.delete(); aq.delete(); dq.delete();
        step();
        @(negedge clock);
        chk({name, "_idle_busy"}, int'(o_busy), 0);
        step();
    endtask

    task automatic watch_quiet(input string name, input int cycles);
        logic act = 1'b0;
        repeat (cycles) begin
            @(negedge clock);
            if (o_busy || !o_tx || o_ram_rd_en) act = 1'b1;
            step();
        end
        chk(name, int'(act), 0);
    endtask

    initial begin
        int n, target;
        mem[0] = 8'h55; mem[1] = 8'hA3; mem[2] = 8'h00; mem[3] = 8'hFF;
        repeat (3) step();
        @(negedge clock);
        chk("reset_tx", int'(o_tx), 1);
        chk("reset_busy", int'(o_busy), 0);
        chk("reset_done", int'(o_done), 0);
        chk("reset_rd_en", int'(o_ram_rd_en), 0);
        chk("reset_rd_addr", int'(o_ram_rd_addr), 0);
        step();
        i_reset = 1'b0;
        step();

        i_ram_full = 1'b1;
        step();
        pulse_start(n);
        expect_dump(n);
        drain("basic");
        chk("addr_hold", int'(o_ram_rd_addr), DEPTH - 1);

        i_ram_full = 1'b0;
        i_start = 1'b1;
        watch_quiet("not_full_quiet", 200);
        i_ram_full = 1'b1;
        watch_quiet("held_start_quiet", 50);
        i_start = 1'b0;
        step();
        pulse_start(n);
        expect_dump(n);
        drain("after_not_full");

        pulse_start(n);
        expect_dump(n);
        target = n + 4 + P + $urandom_range(0, 20);
        while (cyc < target) step();
        repeat (3) begin
            i_start = 1'b1;
            step();
            i_start = 1'b0;
            repeat ($urandom_range(1, 5)) step();
        end
        drain("start_while_busy");

        pulse_start(n);
        expect_dump(n);
        target = n + 4 + 4 * CPB + $urandom_range(0, CPB - 1);
        while (cyc < target) step();
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        fq.delete(); aq.delete(); dq.delete();
        @(negedge clock);
        chk("midreset_tx", int'(o_tx), 1);
        chk("midreset_busy", int'(o_busy), 0);
        step();
        pulse_start(n);
        expect_dump(n);
        drain("after_reset");

        i_reset = 1'b1;
        i_start = 1'b1;
        repeat (3) step();
        i_reset = 1'b0;
        n = cyc;
        expect_dump(n);
        drain("held_across_reset");
        watch_quiet("held_no_redump", 100);
        i_start = 1'b0;
        step();

        repeat (2) begin
            for (int k = 0; k < DEPTH; k++) mem[k] = NB_DATA'($urandom);
            repeat ($urandom_range(1, 10)) step();
            pulse_start(n);
            expect_dump(n);
            drain("random_dump");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
